// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, request kinds,
// interrupt cause codes and the mtvec vectored-mode encoding.
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    FIRE     = 2'd2,
    REDIRECT = 2'd3
  } trap_state_t;

  typedef enum logic [1:0] {
    K_EXCP = 2'd0,
    K_MRET = 2'd1,
    K_IRQ  = 2'd2
  } trap_kind_t;

  localparam logic [3:0] CAUSE_MSI      = 4'd3;
  localparam logic [3:0] CAUSE_MTI      = 4'd7;
  localparam logic [3:0] CAUSE_MEI      = 4'd11;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/trap_sequencer_if.sv
// Bundles the commit-stage requests, csrfile status and csrfile/fetch controls
// seen by the trap sequencer; master is the surrounding pipeline, slave the sequencer.
interface trap_sequencer_if;
  logic        excp_valid;
  logic [3:0]  excp_cause;
  logic [29:0] excp_epc;
  logic [31:0] excp_mtval;
  logic        excp_ack;
  logic        mret_valid;
  logic        mret_ack;
  logic [2:0]  irq_pending;
  logic        mie;
  logic        irq_allow;
  logic [29:0] irq_epc;
  logic        csr_busy;
  logic [31:0] mtvec;
  logic [29:0] mepc;
  logic        take_exception;
  logic        take_interrupt;
  logic        mret;
  logic [29:0] tmu_epc;
  logic [31:0] tmu_mtval;
  logic [3:0]  tmu_mcause;
  logic        flush;
  logic [29:0] redirect_pc;
  logic        busy;

  modport master (
    output excp_valid, excp_cause, excp_epc, excp_mtval, mret_valid,
           irq_pending, mie, irq_allow, irq_epc, csr_busy, mtvec, mepc,
    input  excp_ack, mret_ack, take_exception, take_interrupt, mret,
           tmu_epc, tmu_mtval, tmu_mcause, flush, redirect_pc, busy
  );

  modport slave (
    input  excp_valid, excp_cause, excp_epc, excp_mtval, mret_valid,
           irq_pending, mie, irq_allow, irq_epc, csr_busy, mtvec, mepc,
    output excp_ack, mret_ack, take_exception, take_interrupt, mret,
           tmu_epc, tmu_mtval, tmu_mcause, flush, redirect_pc, busy
  );
endinterface

// File: rtl/trap_irq_select.sv
// Combinational interrupt priority encoder over {MEI,MTI,MSI}:
// MEI beats MSI beats MTI.
module trap_irq_select
  import trap_pkg::*;
(
  input  logic [2:0] irq_pending,
  output logic       valid,
  output logic [3:0] cause
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    valid = |irq_pending;
    cause = '0;
    if (irq_pending[2])      cause = CAUSE_MEI;
    else if (irq_pending[0]) cause = CAUSE_MSI;
    else if (irq_pending[1]) cause = CAUSE_MTI;
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry/exit sequencer: picks one of exception/MRET/interrupt, waits for CSR
// accesses to drain, pulses the csrfile once, then flushes and redirects fetch.
module trap_sequencer
  import trap_pkg::*;
(
  input  logic            cpu_clock_i,
  input  logic            cpu_reset_i,
  trap_sequencer_if.slave bus
);

  trap_state_t state_q, state_d;
  trap_kind_t  kind_q, win_kind;
  logic [3:0]  cause_q, win_cause;
  logic [29:0] epc_q, win_epc;
  logic [31:0] mtval_q, win_mtval;
  logic        irq_valid, irq_eligible, request;
  logic [3:0]  irq_cause;

  trap_irq_select u_irq_select (
    .irq_pending (bus.irq_pending),
    .valid       (irq_valid),
    .cause       (irq_cause)
  );

  assign irq_eligible = bus.irq_allow & bus.mie & irq_valid;
  assign request      = bus.excp_valid | bus.mret_valid | irq_eligible;

  always_comb begin
    win_kind  = K_EXCP;
    win_cause = '0;
    win_epc   = '0;
    win_mtval = '0;
    if (bus.excp_valid) begin
      win_cause = bus.excp_cause;
      win_epc   = bus.excp_epc;
      win_mtval = bus.excp_mtval;
    end else if (bus.mret_valid) begin
      win_kind = K_MRET;
    end else if (irq_eligible) begin
      win_kind  = K_IRQ;
      win_cause = irq_cause;
      win_epc   = bus.irq_epc;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (request) state_d = DRAIN;
      DRAIN:    if (!bus.csr_busy) state_d = FIRE;
      FIRE:     state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      // NOTE: the latched trap fields are cleared too, so FIRE can never expose stale data after reset.
      state_q <= IDLE;
      kind_q  <= K_EXCP;
      cause_q <= '0;
      epc_q   <= '0;
      mtval_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && request) begin
        kind_q  <= win_kind;
        cause_q <= win_cause;
        epc_q   <= win_epc;
        mtval_q <= win_mtval;
      end
    end
  end

  always_comb begin
    bus.take_exception = 1'b0;
    bus.take_interrupt = 1'b0;
    bus.mret           = 1'b0;
    bus.tmu_epc        = '0;
    bus.tmu_mtval      = '0;
    bus.tmu_mcause     = '0;
    bus.flush          = 1'b0;
    bus.redirect_pc    = '0;
    bus.excp_ack       = 1'b0;
    bus.mret_ack       = 1'b0;
    bus.busy           = (state_q != IDLE);
    if (state_q == FIRE) begin
      bus.take_exception = (kind_q == K_EXCP);
      bus.take_interrupt = (kind_q == K_IRQ);
      bus.mret           = (kind_q == K_MRET);
      bus.tmu_epc        = epc_q;
      bus.tmu_mtval      = mtval_q;
      bus.tmu_mcause     = cause_q;
    end else if (state_q == REDIRECT) begin
      bus.flush    = 1'b1;
      bus.excp_ack = (kind_q == K_EXCP);
      bus.mret_ack = (kind_q == K_MRET);
      case (kind_q)
        K_MRET:  bus.redirect_pc = bus.mepc;
        // Vectored mode offsets by the cause word index; other modes jump to the base.
        K_IRQ:   bus.redirect_pc = (bus.mtvec[1:0] == MTVEC_VECTORED)
                                   ? bus.mtvec[31:2] + {26'd0, cause_q}
                                   : bus.mtvec[31:2];
        default: bus.redirect_pc = bus.mtvec[31:2];
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized scoreboard bench for trap_sequencer: the driver predicts pulse events
// from the trap rules, a negedge monitor pops and compares whatever the DUT emits.
module tb_trap_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  trap_sequencer_if bus ();

  trap_sequencer dut (
    .cpu_clock_i (clk),
    .cpu_reset_i (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        te, ti, mr;
    logic        chk_tmu;
    logic [29:0] epc;
    logic [31:0] mtval;
    logic [3:0]  mcause;
    logic        fl;
    logic [29:0] pc;
    logic        ea, ma;
  } ev_t;

  typedef struct {
    logic        ev;
    logic [3:0]  ec;
    logic [29:0] eepc;
    logic [31:0] emtval;
    logic        mv;
    logic [2:0]  pend;
    logic        mie;
    logic        allow;
    logic [29:0] iepc;
    int          nbusy;
    logic [31:0] mtvec;
    logic [29:0] mepc;
    logic        drop_irq;
  } req_t;

  ev_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_inputs();
    bus.excp_valid  = 1'b0;
    bus.excp_cause  = '0;
    bus.excp_epc    = '0;
    bus.excp_mtval  = '0;
    bus.mret_valid  = 1'b0;
    bus.irq_pending = '0;
    bus.mie         = 1'b0;
    bus.irq_allow   = 1'b0;
    bus.irq_epc     = '0;
    bus.csr_busy    = 1'b0;
  endtask

  // Called just after a rising edge; drives one request and predicts its two events.
  task automatic issue(input req_t r);
    int          k;
    int          kind;  // 0 none, 1 exception, 2 mret, 3 interrupt
    logic [3:0]  cause;
    longint      vec;
    ev_t         f, d;
    bus.excp_valid  = r.ev;
    bus.excp_cause  = r.ec;
    bus.excp_epc    = r.eepc;
    bus.excp_mtval  = r.emtval;
    bus.mret_valid  = r.mv;
    bus.irq_pending = r.pend;
    bus.mie         = r.mie;
    bus.irq_allow   = r.allow;
    bus.irq_epc     = r.iepc;
    bus.csr_busy    = (r.nbusy > 0);
    bus.mtvec       = r.mtvec;
    bus.mepc        = r.mepc;
    k = cyc;

    if (r.ev)                                 kind = 1;
    else if (r.mv)                            kind = 2;
    else if (r.allow && r.mie && r.pend != 0) kind = 3;
    else                                      kind = 0;

    if (r.pend[2])      cause = 4'd11;
    else if (r.pend[0]) cause = 4'd3;
    else                cause = 4'd7;

    if (kind != 0) begin
      f = '{cyc: k + 2 + r.nbusy, te: 1'b0, ti: 1'b0, mr: 1'b0, chk_tmu: 1'b1,
            epc: '0, mtval: '0, mcause: '0, fl: 1'b0, pc: '0, ea: 1'b0, ma: 1'b0};
      d = f;
      d.cyc = k + 3 + r.nbusy;
      d.fl  = 1'b1;
      vec   = longint'(r.mtvec) / 4;
      if (kind == 1) begin
        f.te = 1'b1; f.epc = r.eepc; f.mtval = r.emtval; f.mcause = r.ec;
        d.pc = 30'(vec); d.ea = 1'b1;
      end else if (kind == 2) begin
        f.mr = 1'b1; f.chk_tmu = 1'b0;
        d.pc = r.mepc; d.ma = 1'b1;
      end else begin
        f.ti = 1'b1; f.epc = r.iepc; f.mtval = 32'd0; f.mcause = cause;
        if (r.mtvec % 4 == 1) vec = (vec + longint'(cause)) % (longint'(1) << 30);
        d.pc = 30'(vec);
      end
      exp_q.push_back(f);
      exp_q.push_back(d);
    end

    for (int i = 1; i <= r.nbusy + 4; i++) begin
      @(posedge clk); #1;
      if (i == r.nbusy + 1) bus.csr_busy = 1'b0;
      if (i == 1 && r.drop_irq) begin
        bus.irq_pending = '0;
        bus.mie         = 1'b0;
      end
      if (i == 1) check("busy_after_accept", 64'(bus.busy), 64'(kind != 0));
    end
    clear_inputs();
    check("busy_back_idle", 64'(bus.busy), 64'd0);
  endtask

  // Scoreboard monitor: compares on every cycle in which the DUT emits a pulse.
  always @(negedge clk) begin
    ev_t  e;
    logic pulse;
    if (!rst) begin
      pulse = bus.take_exception | bus.take_interrupt | bus.mret |
              bus.flush | bus.excp_ack | bus.mret_ack;
      if (pulse) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 64'(pulse), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle",    64'(cyc),                64'(e.cyc));
          check("take_exception", 64'(bus.take_exception), 64'(e.te));
          check("take_interrupt", 64'(bus.take_interrupt), 64'(e.ti));
          check("mret",           64'(bus.mret),           64'(e.mr));
          check("flush",          64'(bus.flush),          64'(e.fl));
          check("redirect_pc",    64'(bus.redirect_pc),    64'(e.pc));
          check("excp_ack",       64'(bus.excp_ack),       64'(e.ea));
          check("mret_ack",       64'(bus.mret_ack),       64'(e.ma));
          if (e.chk_tmu) begin
            check("tmu_epc",    64'(bus.tmu_epc),    64'(e.epc));
            check("tmu_mtval",  64'(bus.tmu_mtval),  64'(e.mtval));
            check("tmu_mcause", 64'(bus.tmu_mcause), 64'(e.mcause));
          end
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          check("missing_pulse", 64'(cyc), 64'(exp_q[0].cyc));
          void'(exp_q.pop_front());
        end
        check("quiet_outputs",
              64'((bus.tmu_epc != 0) || (bus.tmu_mtval != 0) ||
                  (bus.tmu_mcause != 0) || (bus.redirect_pc != 0)), 64'd0);
      end
    end
  end

  function automatic req_t blank();
    req_t r;
    r = '{ev: 1'b0, ec: '0, eepc: '0, emtval: '0, mv: 1'b0, pend: '0, mie: 1'b0,
          allow: 1'b0, iepc: '0, nbusy: 0, mtvec: '0, mepc: '0, drop_irq: 1'b0};
    return r;
  endfunction

  initial begin
    req_t        r;
    logic [31:0] tmp;
    int          waited;
    clear_inputs();
    bus.mtvec = '0;
    bus.mepc  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",  64'(bus.busy), 64'd0);
    check("reset_flush", 64'(bus.flush), 64'd0);
    check("reset_take",  64'({bus.take_exception, bus.take_interrupt, bus.mret}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Exception, direct target.
    r = blank();
    r.ev = 1'b1; r.ec = 4'd2; r.eepc = 30'h40; r.emtval = 32'hDEADBEEF; r.mtvec = 32'h80000000;
    issue(r);

    // All three interrupts pending, vectored mtvec: MEI wins.
    r = blank();
    r.pend = 3'b111; r.mie = 1'b1; r.allow = 1'b1; r.iepc = 30'h123; r.mtvec = 32'h80000001;
    issue(r);

    // MRET back to mepc.
    r = blank();
    r.mv = 1'b1; r.mepc = 30'h10; r.mtvec = 32'h80000000;
    issue(r);

    // Exception, MRET and MSI together: only the exception is taken.
    r = blank();
    r.ev = 1'b1; r.ec = 4'd5; r.eepc = 30'h200; r.emtval = 32'h1234; r.mv = 1'b1;
    r.pend = 3'b001; r.mie = 1'b1; r.allow = 1'b1; r.mtvec = 32'h00001001;
    issue(r);

    // Five busy DRAIN cycles before FIRE.
    r = blank();
    r.ev = 1'b1; r.ec = 4'd7; r.eepc = 30'h3FFFFFFF; r.emtval = 32'hFFFFFFFF;
    r.nbusy = 5; r.mtvec = 32'hFFFFFFFD;
    issue(r);

    // Vectored add wraps at 2^30; interrupt committed despite MTI/MIE dropping in DRAIN.
    r = blank();
    r.pend = 3'b010; r.mie = 1'b1; r.allow = 1'b1; r.iepc = 30'h55; r.nbusy = 2;
    r.mtvec = 32'hFFFFFFFD; r.drop_irq = 1'b1;
    issue(r);

    // Interrupt masked by MIE: nothing happens.
    r = blank();
    r.pend = 3'b100; r.allow = 1'b1; r.mtvec = 32'h100;
    issue(r);

    // Reset in the middle of DRAIN abandons the sequence silently.
    bus.excp_valid = 1'b1; bus.excp_cause = 4'd1; bus.csr_busy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_in_drain", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    check("busy_after_reset", 64'(bus.busy), 64'd0);
    repeat (6) @(posedge clk);
    #1;

    for (int n = 0; n < 60; n++) begin
      r = blank();
      r.ev     = ($urandom_range(0, 3) == 0);
      r.ec     = 4'($urandom_range(0, 15));
      tmp      = $urandom(); r.eepc = tmp[29:0];
      r.emtval = $urandom();
      r.mv     = ($urandom_range(0, 3) == 0);
      r.pend   = 3'($urandom_range(0, 7));
      r.mie    = ($urandom_range(0, 3) != 0);
      r.allow  = ($urandom_range(0, 3) != 0);
      tmp      = $urandom(); r.iepc = tmp[29:0];
      r.nbusy  = $urandom_range(0, 3);
      r.mtvec  = $urandom();
      tmp      = $urandom(); r.mepc = tmp[29:0];
      r.drop_irq = ($urandom_range(0, 1) == 1);
      issue(r);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
